// File: rtl/img_rx_ctrl.sv
// img_rx_ctrl
//   Frame sequencer between the UART byte receiver and the Sobel line-buffer
//   input. It accepts one byte per receiver strobe, tags the byte with its
//   column/row position inside an IMG_W x IMG_H frame, and flags row and frame
//   ends. A new frame is held off until the downstream pipeline acknowledges
//   the previous one.
//
//   Optional feature, build macro RX_TIMEOUT_EN:
//     defined   - an idle timer runs while receiving; if TIMEOUT_MAX cycles pass
//                 with no byte, the partial frame is aborted (err_timeout pulse)
//     undefined - no timer, err_timeout is tied low and a frame waits forever
//
// Ports
//   sclk        in   system clock
//   rst_n       in   asynchronous active-low reset
//   rx_data     in   received byte, valid with rx_flag
//   rx_flag     in   one-cycle byte strobe
//   done_ack    in   downstream has consumed the frame (level or pulse)
//   pix_data    out  registered pixel byte
//   pix_valid   out  one-cycle pixel strobe
//   col_cnt     out  column of the emitted pixel (held until the next pixel)
//   row_cnt     out  row of the emitted pixel (held until the next pixel)
//   row_end     out  pulse with the last pixel of each row
//   frame_end   out  pulse with the last pixel of the frame
//   frame_done  out  level, frame complete and awaiting done_ack
//   busy        out  level, frame reception in progress
//   overrun     out  sticky, a byte arrived while waiting for done_ack
//   err_timeout out  one-cycle abort pulse
//
// State table
//   state | meaning
//   IDLE  | waiting for the first byte of a frame, position is 0,0
//   RECV  | receiving a frame, nxt_col/nxt_row hold the next pixel position
//   DONE  | frame complete, bytes are dropped until done_ack

module img_rx_ctrl #(
  parameter int IMG_W       = 64,
  parameter int IMG_H       = 64,
  parameter int TIMEOUT_MAX = 104159
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_flag,
  input  logic       done_ack,
  output logic [7:0] pix_data,
  output logic       pix_valid,
  output logic [9:0] col_cnt,
  output logic [9:0] row_cnt,
  output logic       row_end,
  output logic       frame_end,
  output logic       frame_done,
  output logic       busy,
  output logic       overrun,
  output logic       err_timeout
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [9:0]  LAST_COL = 10'(IMG_W - 1);
  localparam logic [9:0]  LAST_ROW = 10'(IMG_H - 1);
  localparam logic [16:0] TMO_LOAD = 17'(TIMEOUT_MAX);

  if (IMG_W < 2 || IMG_W > 1023) begin : g_chk_w
    $error("img_rx_ctrl: IMG_W out of range 2..1023");
  end
  if (IMG_H < 2 || IMG_H > 1023) begin : g_chk_h
    $error("img_rx_ctrl: IMG_H out of range 2..1023");
  end
  if (TIMEOUT_MAX < 1 || TIMEOUT_MAX > 131071) begin : g_chk_tmo
    $error("img_rx_ctrl: TIMEOUT_MAX must fit in 17 bits and be nonzero");
  end

  logic [1:0] state;
  logic [9:0] nxt_col;
  logic [9:0] nxt_row;
  logic       last_col;
  logic       last_row;
  logic       tmo_hit;

  assign last_col = (nxt_col == LAST_COL);
  assign last_row = (nxt_row == LAST_ROW);

`ifdef RX_TIMEOUT_EN
  // Down-counter reloaded by every byte (and whenever not receiving). It
  // reaches zero TIMEOUT_MAX cycles after the last byte; the abort is taken on
  // the following edge only if no byte arrives in that same cycle, so a byte
  // landing exactly at expiry still wins.
  logic [16:0] idle_tmr;

  assign tmo_hit = (state == ST_RECV) && !rx_flag && (idle_tmr == 17'd0);

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      idle_tmr    <= TMO_LOAD;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= tmo_hit;
      if (state != ST_RECV || rx_flag) begin
        idle_tmr <= TMO_LOAD;
      end else if (idle_tmr != 17'd0) begin
        idle_tmr <= idle_tmr - 17'd1;
      end
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      nxt_col    <= 10'd0;
      nxt_row    <= 10'd0;
      pix_data   <= 8'd0;
      pix_valid  <= 1'b0;
      col_cnt    <= 10'd0;
      row_cnt    <= 10'd0;
      row_end    <= 1'b0;
      frame_end  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      row_end   <= 1'b0;
      frame_end <= 1'b0;

      case (state)
        ST_IDLE, ST_RECV: begin
          if (rx_flag) begin
            // IDLE always sits at 0,0, so the first pixel of a frame goes
            // through the same position logic as every other pixel.
            pix_valid <= 1'b1;
            pix_data  <= rx_data;
            col_cnt   <= nxt_col;
            row_cnt   <= nxt_row;
            row_end   <= last_col;
            busy      <= 1'b1;
            state     <= ST_RECV;
            if (state == ST_IDLE) begin
              overrun <= 1'b0;
            end
            if (last_col) begin
              nxt_col <= 10'd0;
              if (last_row) begin
                nxt_row    <= 10'd0;
                frame_end  <= 1'b1;
                frame_done <= 1'b1;
                busy       <= 1'b0;
                state      <= ST_DONE;
              end else begin
                nxt_row <= nxt_row + 10'd1;
              end
            end else begin
              nxt_col <= nxt_col + 10'd1;
            end
          end else if (tmo_hit) begin
            busy    <= 1'b0;
            state   <= ST_IDLE;
            nxt_col <= 10'd0;
            nxt_row <= 10'd0;
          end
        end

        ST_DONE: begin
          if (rx_flag) begin
            overrun <= 1'b1;
          end
          if (done_ack) begin
            frame_done <= 1'b0;
            state      <= ST_IDLE;
            nxt_col    <= 10'd0;
            nxt_row    <= 10'd0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
